// File: rtl/serbcd_pkg.sv
// Shared types and constants for the serial BCD <-> excess-3 frame converter.
package serbcd_pkg;

  typedef enum logic {BCD2XS3, XS32BCD} conv_mode_e;
  typedef enum logic {IDLE, RUN} frame_state_e;

  localparam logic [3:0] XS3_ADD_K = 4'b0011;
  localparam logic [3:0] XS3_SUB_K = 4'b1101;
  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [3:0] XS3_MIN   = 4'd3;
  localparam logic [3:0] XS3_MAX   = 4'd12;

  // Input-side legality of one nibble for the given conversion direction.
  function automatic logic digit_invalid(input conv_mode_e m, input logic [3:0] n);
    if (m == BCD2XS3) return (n > BCD_MAX);
    return (n < XS3_MIN) || (n > XS3_MAX);
  endfunction

endpackage

// File: rtl/serbcd_bit_adder.sv
// One-bit serial full adder; carry is registered and only advances when en is high.
module serbcd_bit_adder (
  input  logic clk,
  input  logic rst_b,
  input  logic en,
  input  logic clr_carry,
  input  logic a,
  input  logic k,
  output logic sum_bit,
  output logic carry_q
);

  logic [1:0] sum;
  logic       cin;

  assign cin     = clr_carry ? 1'b0 : carry_q;
  assign sum     = {1'b0, a} + {1'b0, cin} + {1'b0, k};
  assign sum_bit = sum[0];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)  carry_q <= 1'b0;
    else if (en) carry_q <= sum[1];
  end

endmodule

// File: rtl/serbcd_x3_frame_conv.sv
// Serial LSB-first frame converter, BCD <-> excess-3, with parallel word assembly.
// Optional saturating invalid-digit counter on err_cnt when SERBCD_ERRCNT_EN is defined.
module serbcd_x3_frame_conv
  import serbcd_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int WORD_W  = 4*NDIGITS
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              inval,
  input  logic              in,
  input  logic              sof,
  input  logic              mode,
  output logic              out,
  output logic              outval,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic              frame_err,
  output logic              frame_abort
`ifdef SERBCD_ERRCNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam logic [3:0] LAST_D = 4'(NDIGITS-1);

  frame_state_e      state_q, state_d;
  logic [1:0]        bit_cnt_q, bit_cnt_d;
  logic [3:0]        digit_cnt_q, digit_cnt_d;
  conv_mode_e        mode_q, mode_d;
  logic [WORD_W-1:0] stage_q, stage_d;
  logic [2:0]        nib_q, nib_d;
  logic              err_q, err_d;

  logic              out_q, outval_q, word_valid_q, frame_err_q, frame_abort_q;
  logic [WORD_W-1:0] word_out_q;

  logic        start, consume, abort, last, digit_bad;
  logic [1:0]  bc;
  logic [3:0]  dc;
  logic [5:0]  idx;
  conv_mode_e  md;
  logic [3:0]  kvec;
  logic        sum_bit;

  // A sof cycle overrides position and mode so its bit is digit 0 bit 0 of the new frame.
  assign start     = inval & sof;
  assign consume   = inval & (sof | (state_q == RUN));
  assign abort     = start & (state_q == RUN) & ~((bit_cnt_q == 2'd0) && (digit_cnt_q == 4'd0));
  assign bc        = start ? 2'd0 : bit_cnt_q;
  assign dc        = start ? 4'd0 : digit_cnt_q;
  assign md        = start ? conv_mode_e'(mode) : mode_q;
  assign kvec      = (md == XS32BCD) ? XS3_SUB_K : XS3_ADD_K;
  assign idx       = {dc, bc};
  assign last      = consume & (bc == 2'd3) & (dc == LAST_D);
  assign digit_bad = consume & (bc == 2'd3) & digit_invalid(md, {in, nib_q});

  serbcd_bit_adder u_add (
    .clk      (clk),
    .rst_b    (rst_b),
    .en       (consume),
    .clr_carry(bc == 2'd0),
    .a        (in),
    .k        (kvec[bc]),
    .sum_bit  (sum_bit),
    .carry_q  ()
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    digit_cnt_d = digit_cnt_q;
    mode_d      = mode_q;
    stage_d     = stage_q;
    nib_d       = nib_q;
    err_d       = err_q;
    if (start) begin
      mode_d  = conv_mode_e'(mode);
      stage_d = '0;
      err_d   = 1'b0;
    end
    if (consume) begin
      if (bc != 2'd3) nib_d[bc] = in;
      for (int i = 0; i < WORD_W; i++)
        if (6'(i) == idx) stage_d[i] = sum_bit;
      err_d       = err_d | digit_bad;
      bit_cnt_d   = bc + 2'd1;
      digit_cnt_d = (bc == 2'd3) ? dc + 4'd1 : dc;
      state_d     = RUN;
      if (last) begin
        state_d     = IDLE;
        bit_cnt_d   = 2'd0;
        digit_cnt_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q       <= IDLE;
      bit_cnt_q     <= 2'd0;
      digit_cnt_q   <= 4'd0;
      mode_q        <= BCD2XS3;
      stage_q       <= '0;
      nib_q         <= 3'd0;
      err_q         <= 1'b0;
      out_q         <= 1'b0;
      outval_q      <= 1'b0;
      word_valid_q  <= 1'b0;
      word_out_q    <= '0;
      frame_err_q   <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      digit_cnt_q   <= digit_cnt_d;
      mode_q        <= mode_d;
      stage_q       <= stage_d;
      nib_q         <= nib_d;
      err_q         <= err_d;
      outval_q      <= consume;
      word_valid_q  <= last;
      frame_abort_q <= abort;
      if (consume) out_q <= sum_bit;
      if (last) begin
        word_out_q  <= stage_d;
        frame_err_q <= err_d;
      end
    end
  end

`ifdef SERBCD_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                             err_cnt_q <= 8'd0;
    else if (digit_bad && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_cnt = err_cnt_q;
`endif

  assign out         = out_q;
  assign outval      = outval_q;
  assign word_out    = word_out_q;
  assign word_valid  = word_valid_q;
  assign frame_err   = frame_err_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_serbcd_x3_frame_conv.sv
// Directed bench: one NDIGITS=1 instance and one NDIGITS=4 instance, hand-computed expectations.
module tb_serbcd_x3_frame_conv;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  logic inv1 = 0, din1 = 0, sof1 = 0, md1 = 0;
  logic out1, outval1, word_valid1, frame_err1, frame_abort1;
  logic [3:0] word_out1;

  logic inv4 = 0, din4 = 0, sof4 = 0, md4 = 0;
  logic out4, outval4, word_valid4, frame_err4, frame_abort4;
  logic [15:0] word_out4;

`ifdef SERBCD_ERRCNT_EN
  logic [7:0] err_cnt1, err_cnt4;
`endif

  serbcd_x3_frame_conv #(.NDIGITS(1)) u1 (
    .clk(clk), .rst_b(rst_b), .inval(inv1), .in(din1), .sof(sof1), .mode(md1),
    .out(out1), .outval(outval1), .word_out(word_out1), .word_valid(word_valid1),
    .frame_err(frame_err1), .frame_abort(frame_abort1)
`ifdef SERBCD_ERRCNT_EN
    , .err_cnt(err_cnt1)
`endif
  );

  serbcd_x3_frame_conv #(.NDIGITS(4)) u4 (
    .clk(clk), .rst_b(rst_b), .inval(inv4), .in(din4), .sof(sof4), .mode(md4),
    .out(out4), .outval(outval4), .word_out(word_out4), .word_valid(word_valid4),
    .frame_err(frame_err4), .frame_abort(frame_abort4)
`ifdef SERBCD_ERRCNT_EN
    , .err_cnt(err_cnt4)
`endif
  );

  int total = 0, bad = 0;
  int ocnt = 0, wv_cnt = 0, ab_cnt = 0;
  logic [15:0] obits = '0, wo_at_abort = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock on the 4-digit instance; outputs sampled 1ns after the edge.
  task automatic cyc4(input logic v, input logic b, input logic s, input logic m);
    inv4 = v; din4 = b; sof4 = s; md4 = m;
    @(posedge clk); #1;
    if (outval4) begin obits = {out4, obits[15:1]}; ocnt++; end
    if (word_valid4) wv_cnt++;
    if (frame_abort4) begin ab_cnt++; wo_at_abort = word_out4; end
  endtask

  task automatic frame4(input logic [15:0] d, input logic m, input int unsigned gmax);
    ocnt = 0; wv_cnt = 0;
    for (int j = 0; j < 16; j++) begin
      repeat ($urandom_range(gmax, 0)) cyc4(1'b0, 1'b0, 1'b0, 1'b0);
      cyc4(1'b1, d[j], j == 0, m);
    end
    inv4 = 0; sof4 = 0;
  endtask

  initial begin
    logic [3:0] n5, e8;
    logic [15:0] p;
    n5 = 4'h5; e8 = 4'h8;

    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_outval4", outval4, 0);
    chk("rst_word4", word_out4, 0);
    chk("rst_wv4", word_valid4, 0);
    chk("rst_err4", frame_err4, 0);
    chk("rst_abort4", frame_abort4, 0);
    chk("rst_word1", word_out1, 0);
    rst_b = 1'b1;
    @(posedge clk); #1;

    // NDIGITS=1: BCD 5 -> XS3 8
    for (int i = 0; i < 4; i++) begin
      inv1 = 1; din1 = n5[i]; sof1 = (i == 0); md1 = 0;
      @(posedge clk); #1;
      chk("t1_outval", outval1, 1);
      chk("t1_out", out1, e8[i]);
    end
    chk("t1_wv", word_valid1, 1);
    chk("t1_word", word_out1, 4'h8);
    chk("t1_err", frame_err1, 0);
    inv1 = 0; sof1 = 0;
    @(posedge clk); #1;
    chk("t1_wv_drop", word_valid1, 0);
    chk("t1_outval_drop", outval1, 0);

    // NDIGITS=4: digits 9,3,2,1 mode 0, then back-to-back mode 1 round trip
    frame4(16'h1239, 1'b0, 0);
    chk("t2_wv_now", word_valid4, 1);
    chk("t2_word", word_out4, 16'h456C);
    chk("t2_serial", obits, 16'h456C);
    chk("t2_err", frame_err4, 0);
    chk("t2_ocnt", ocnt, 16);
    frame4(16'h456C, 1'b1, 0);
    chk("t3_word", word_out4, 16'h1239);
    chk("t3_serial", obits, 16'h1239);
    chk("t3_wv_cnt", wv_cnt, 1);
    chk("t3_err", frame_err4, 0);

    // Invalid BCD digit A in slot 1
    frame4(16'h32A1, 1'b0, 0);
    chk("t4_word", word_out4, 16'h65D4);
    chk("t4_err", frame_err4, 1);
`ifdef SERBCD_ERRCNT_EN
    chk("t4_errcnt", err_cnt4, 1);
`endif

    // Random stalls inside digits
    frame4(16'h1239, 1'b0, 5);
    chk("t5_word", word_out4, 16'h456C);
    chk("t5_serial", obits, 16'h456C);
    chk("t5_ocnt", ocnt, 16);
    chk("t5_wv_cnt", wv_cnt, 1);
    chk("t5_err_clr", frame_err4, 0);
    cyc4(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_idle_outval", outval4, 0);

    // Abort: digits F,0 then digit2 bit0, new sof lands on digit2 bit1
    p = 16'h010F; ab_cnt = 0; wv_cnt = 0;
    for (int j = 0; j < 9; j++) cyc4(1'b1, p[j], j == 0, 1'b0);
    chk("t6_no_wv", wv_cnt, 0);
    frame4(16'h8765, 1'b1, 0);
    chk("t6_abort_cnt", ab_cnt, 1);
    chk("t6_word_held", wo_at_abort, 16'h456C);
    chk("t6_word", word_out4, 16'h5432);
    chk("t6_err", frame_err4, 0);
    chk("t6_wv_cnt", wv_cnt, 1);
`ifdef SERBCD_ERRCNT_EN
    chk("t6_errcnt", err_cnt4, 2);
`endif

    // Reset mid-frame
    cyc4(1'b1, 1'b1, 1'b1, 1'b0);
    cyc4(1'b1, 1'b0, 1'b0, 1'b0);
    cyc4(1'b1, 1'b1, 1'b0, 1'b0);
    rst_b = 1'b0; #1;
    chk("t7_outval", outval4, 0);
    chk("t7_out", out4, 0);
    chk("t7_word", word_out4, 0);
    chk("t7_wv", word_valid4, 0);
    chk("t7_err", frame_err4, 0);
    chk("t7_abort", frame_abort4, 0);
`ifdef SERBCD_ERRCNT_EN
    chk("t7_errcnt", err_cnt4, 0);
`endif
    @(posedge clk); #1;
    rst_b = 1'b1;
    ocnt = 0; ab_cnt = 0;
    repeat (3) cyc4(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t7_idle_ignore", ocnt, 0);
    frame4(16'h1239, 1'b0, 0);
    chk("t7_word_after", word_out4, 16'h456C);
    chk("t7_no_abort", ab_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serbcd_x3_frame_conv.md
Name: serbcd_x3_frame_conv

Overview:
- Parametrised successor to the single-digit serial BCD-to-excess-3 converter.
- Converts a serial, LSB-first frame of NDIGITS 4-bit digits.
- Direction is selectable per frame:
  - BCD to XS3: add 3.
  - XS3 to BCD: subtract 3.
- Provides:
  - the converted serial bit stream;
  - an assembled parallel word;
  - a per-frame invalid-digit flag.
- Sits between a serial digit link and the parallel numeric datapath.

Parameters:
- NDIGITS, 4, number of digits per frame (1 to 16).
- WORD_W, 4*NDIGITS, derived width of the parallel word. Do not override.

Ports:
- clk  input  1  clock
- rst_b  input  1  reset, asynchronous, active-low
- inval  input  1  qualifies in, sof and mode for the current cycle
- in  input  1  serial data bit; LSB first within a digit, digit 0 first
- sof  input  1  start of frame; valid only with inval; marks bit 0 of digit 0
- mode  input  1  0 = BCD to XS3, 1 = XS3 to BCD; sampled only on a sof cycle
- out  output  1  converted serial bit
- outval  output  1  qualifies out
- word_out  output  WORD_W  converted frame; digit d in bits [4d+3:4d]
- word_valid  output  1  one-cycle pulse: word_out and frame_err updated
- frame_err  output  1  at least one invalid input digit in the last completed frame
- frame_abort  output  1  one-cycle pulse: partial frame discarded

Behaviour:
- Reset values: all outputs 0; state IDLE; bit_cnt, digit_cnt, carry and staging register 0.
- States:
  - IDLE:
    - inval & sof starts RUN and consumes that bit as bit 0 of digit 0.
    - inval without sof is ignored; outval stays 0.
  - RUN: every inval cycle consumes one bit.
    - After bit 3 of digit NDIGITS-1, return to IDLE.
    - inval & sof on the very next cycle begins a new frame; no bubble is required.
- Per-bit arithmetic:
  - sum = in + carry_eff + K[bit_cnt], where K = 4'b0011 for mode 0 and 4'b1101 for mode 1.
  - carry_eff = 0 when bit_cnt == 0, otherwise the registered carry.
  - out gets the sum LSB; carry gets the sum MSB.
  - The carry out of bit 3 is discarded, so each digit is computed modulo 16.
- Latency: out and outval are registered one cycle after the consuming inval cycle.
  - outval = 1 only for consumed bits; 0 on stall cycles and on ignored bits.
- Stall: with inval low, all state is held, including the mid-digit carry.
- Mode is latched at sof and held for the whole frame. mode on non-sof cycles is don't-care.
- Assembly: each result bit is written to staging[4*digit_cnt + bit_cnt].
  - On the final bit, staging (including that bit) is copied to word_out and word_valid pulses, aligned with the final outval.
  - word_out holds its value until the next completed frame.
- Validity check:
  - Each input nibble is assembled; at bit 3 it is checked:
    - mode 0: invalid if greater than 9;
    - mode 1: invalid if less than 3 or greater than 12.
  - Invalid digits are still converted modulo 16.
  - A sticky error bit is cleared at sof and copied to frame_err with word_valid.
- sof with inval while in RUN and not at bit 0 of digit 0:
  - frame_abort pulses one cycle later;
  - staging and the error bit are discarded; word_out and frame_err are unchanged;
  - the new frame starts with that bit.
- Reset mid-frame: immediate return to IDLE with all outputs 0. There is no abort pulse.

Optional Feature:
- Macro: SERBCD_ERRCNT_EN.
- Defined: adds output err_cnt [7:0], a saturating count of invalid digits.
  - Reset value 0.
  - Increments at each invalid-digit detection, including digits in frames later aborted.
  - Holds at 255.
- Not defined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package serbcd_pkg:
  - typedef enum conv_mode_e {BCD2XS3, XS32BCD};
  - constants XS3_ADD_K = 4'b0011, XS3_SUB_K = 4'b1101, BCD_MAX = 9, XS3_MIN = 3, XS3_MAX = 12;
  - typedef enum frame_state_e {IDLE, RUN}.
- Sub-module serbcd_bit_adder: one-bit serial full adder with a registered carry.
  - Inputs: en, clr_carry, a, k.
  - Outputs: sum_bit, carry_q.
  - The top level instantiates it once.

Test Plan:
- NDIGITS=1, mode 0, sof with bits 1,0,1,0 (BCD 5) -> out 0,0,0,1 with outval on the next 4 cycles; word_out 4'h8; word_valid once; frame_err 0.
- NDIGITS=4, mode 0, digits sent 9,3,2,1 -> word_out 16'h456C; frame_err 0; back-to-back sof on the next cycle accepted.
- NDIGITS=4, mode 1, digits C,6,5,4 -> word_out 16'h1239, i.e. the round trip.
- mode 0, digit 4'hA in one slot -> that nibble 4'hD; frame_err 1 at word_valid; err_cnt 1 when SERBCD_ERRCNT_EN is defined.
- Random inval gaps of 0 to 5 cycles inside digits -> results identical to the gap-free run; outval count equals 4*NDIGITS.
- sof at digit 2 bit 1 -> frame_abort pulse, word_out unchanged, new frame completes correctly. rst_b low mid-frame -> all outputs 0, state IDLE.
